// File: rtl/adma2_pkg.sv
// Shared types and constants for the ADMA2 descriptor sequencer: state encoding,
// descriptor action codes, descriptor field positions and error-state codes.
package adma2_pkg;

   // Encodings of FDS and TFR match the error-state codes reported to the host.
   typedef enum logic [1:0] {
      StStop = 2'b00,
      StFds  = 2'b01,
      StCadr = 2'b10,
      StTfr  = 2'b11
   } adma2_state_e;

   localparam logic [1:0] ACT_NOP  = 2'b00;
   localparam logic [1:0] ACT_TRAN = 2'b10;
   localparam logic [1:0] ACT_LINK = 2'b11;

   localparam int unsigned DescValidBit = 0;
   localparam int unsigned DescEndBit   = 1;
   localparam int unsigned DescIntBit   = 2;
   localparam int unsigned DescActLsb   = 4;
   localparam int unsigned DescLenLsb   = 16;
   localparam int unsigned DescAddrLsb  = 32;

   localparam logic [1:0] ERR_ST_STOP = 2'b00;
   localparam logic [1:0] ERR_ST_FDS  = 2'b01;
   localparam logic [1:0] ERR_ST_TFR  = 2'b11;

   localparam logic [16:0] MaxTfrLen = 17'h1_0000;

endpackage

// File: rtl/adma2_sequencer_if.sv
// Descriptor-fetch and data-mover handshake bundle of the ADMA2 sequencer.
// master = sequencer side, slave = memory/data-mover side.
interface adma2_sequencer_if;

   logic        desc_req;
   logic [63:0] desc_addr;
   logic        desc_ack;
   logic [63:0] desc_data;
   logic        tfr_start;
   logic [31:0] tfr_addr;
   logic [16:0] tfr_len;
   logic        tfr_done;
   logic        tfr_error;

   modport master (
      output desc_req, desc_addr, tfr_start, tfr_addr, tfr_len,
      input  desc_ack, desc_data, tfr_done, tfr_error
   );

   modport slave (
      input  desc_req, desc_addr, tfr_start, tfr_addr, tfr_len,
      output desc_ack, desc_data, tfr_done, tfr_error
   );

endinterface

// File: rtl/adma2_desc_decode.sv
// Combinational ADMA2 descriptor field extraction; a length field of 0 means 65536 bytes.
module adma2_desc_decode
   import adma2_pkg::*;
(
   input  logic [63:0] desc_i,
   output logic        valid_o,
   output logic        end_o,
   output logic        int_o,
   output logic [1:0]  act_o,
   output logic [31:0] addr_o,
   output logic [16:0] len_o
);

   logic [1:0]  act_raw;
   logic [15:0] len_raw;
   logic        unused_rsv;

   always_comb begin
      valid_o = desc_i[DescValidBit];
      end_o   = desc_i[DescEndBit];
      int_o   = desc_i[DescIntBit];
      act_raw = desc_i[DescActLsb +: 2];
      // The reserved code 01 behaves exactly like a nop.
      act_o   = (act_raw == 2'b01) ? ACT_NOP : act_raw;
      len_raw = desc_i[DescLenLsb +: 16];
      len_o   = (len_raw == 16'd0) ? MaxTfrLen : {1'b0, len_raw};
      addr_o  = desc_i[DescAddrLsb +: 32];
   end

   assign unused_rsv = ^{desc_i[15:6], desc_i[3]};

endmodule

// File: rtl/adma2_sequencer.sv
// ADMA2 descriptor-chain controller: fetch, decode, hand transfers to the data mover.
// Optional fetch watchdog enabled by defining ADMA_FETCH_TIMEOUT_EN.
module adma2_sequencer
   import adma2_pkg::*;
#(
`ifdef ADMA_FETCH_TIMEOUT_EN
   parameter int unsigned FETCH_TIMEOUT = 1024
`endif
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [63:0]              Initial_ADMA_System_Address,
   adma2_sequencer_if.master        dma_if,
   output logic [63:0]              ADMA_System_Address_Register,
   output logic [1:0]               ADMA_Error_State,
   output logic                     DMA_Interrupt,
   output logic                     ADMA_Error,
   output logic                     Transfer_complete,
   input  logic                     ack_DMA_Interrupt,
   input  logic                     ack_ADMA_Error,
   input  logic                     ack_Transfer_complete
);

   adma2_state_e state_q, state_d;
   logic [63:0]  addr_q, addr_d;
   logic [63:0]  desc_q, desc_d;
   logic         first_q, first_d;
   logic         int_q, int_d;
   logic         err_q, err_d;
   logic         tc_q, tc_d;
   logic [1:0]   err_st_q, err_st_d;
   logic         set_int, set_err, set_tc;

   logic         d_valid, d_end, d_int;
   logic [1:0]   d_act;
   logic [31:0]  d_addr;
   logic [16:0]  d_len;

`ifdef ADMA_FETCH_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(FETCH_TIMEOUT) + 1;
   logic [CntW-1:0] cnt_q, cnt_d;
`endif

   adma2_desc_decode u_decode (
      .desc_i  (desc_q),
      .valid_o (d_valid),
      .end_o   (d_end),
      .int_o   (d_int),
      .act_o   (d_act),
      .addr_o  (d_addr),
      .len_o   (d_len)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      desc_d   = desc_q;
      first_d  = 1'b0;
      err_st_d = err_st_q;
      set_int  = 1'b0;
      set_err  = 1'b0;
      set_tc   = 1'b0;
`ifdef ADMA_FETCH_TIMEOUT_EN
      cnt_d    = '0;
`endif
      unique case (state_q)
         StStop: begin
            if (start && !abort) begin
               addr_d  = Initial_ADMA_System_Address;
               state_d = StFds;
            end
         end
         StFds: begin
            if (dma_if.desc_ack) begin
               desc_d  = dma_if.desc_data;
               state_d = StCadr;
            end
`ifdef ADMA_FETCH_TIMEOUT_EN
            else if (cnt_q == CntW'(FETCH_TIMEOUT - 1)) begin
               set_err  = 1'b1;
               err_st_d = ERR_ST_FDS;
               state_d  = StStop;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
`endif
         end
         StCadr: begin
            if (!d_valid) begin
               set_err  = 1'b1;
               err_st_d = ERR_ST_FDS;
               state_d  = StStop;
            end else if (d_act == ACT_TRAN) begin
               addr_d  = addr_q + 64'd8;
               first_d = 1'b1;
               state_d = StTfr;
            end else begin
               // Link and nop descriptors complete here; transfers complete on tfr_done.
               addr_d  = (d_act == ACT_LINK) ? {32'b0, d_addr} : addr_q + 64'd8;
               set_int = d_int;
               set_tc  = d_end;
               state_d = d_end ? StStop : StFds;
            end
         end
         StTfr: begin
            if (dma_if.tfr_error) begin
               set_err  = 1'b1;
               err_st_d = ERR_ST_TFR;
               state_d  = StStop;
            end else if (dma_if.tfr_done) begin
               set_int = d_int;
               set_tc  = d_end;
               state_d = d_end ? StStop : StFds;
            end
         end
         default: state_d = StStop;
      endcase

      if (abort && (state_q != StStop)) begin
         state_d  = StStop;
         addr_d   = addr_q;
         first_d  = 1'b0;
         err_st_d = err_st_q;
         set_int  = 1'b0;
         set_err  = 1'b0;
         set_tc   = 1'b0;
      end

      // A set in the same cycle as the host ack keeps the flag asserted.
      int_d = set_int | (int_q & ~ack_DMA_Interrupt);
      err_d = set_err | (err_q & ~ack_ADMA_Error);
      tc_d  = set_tc  | (tc_q  & ~ack_Transfer_complete);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StStop;
         addr_q   <= '0;
         desc_q   <= '0;
         first_q  <= 1'b0;
         int_q    <= 1'b0;
         err_q    <= 1'b0;
         tc_q     <= 1'b0;
         err_st_q <= ERR_ST_STOP;
`ifdef ADMA_FETCH_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         desc_q   <= desc_d;
         first_q  <= first_d;
         int_q    <= int_d;
         err_q    <= err_d;
         tc_q     <= tc_d;
         err_st_q <= err_st_d;
`ifdef ADMA_FETCH_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign dma_if.desc_req  = (state_q == StFds);
   assign dma_if.desc_addr = (state_q == StFds) ? addr_q : '0;
   assign dma_if.tfr_start = (state_q == StTfr) && first_q;
   assign dma_if.tfr_addr  = (state_q == StTfr) ? d_addr : '0;
   assign dma_if.tfr_len   = (state_q == StTfr) ? d_len : '0;

   assign ADMA_System_Address_Register = addr_q;
   assign ADMA_Error_State             = err_st_q;
   assign DMA_Interrupt                = int_q;
   assign ADMA_Error                   = err_q;
   assign Transfer_complete            = tc_q;

endmodule

// File: tb/tb_adma2_sequencer.sv
// Scoreboard bench for adma2_sequencer: expected fetches/transfers are queued with the
// stimulus and popped by a monitor whenever the DUT issues a request or a tfr_start.
module tb_adma2_sequencer;

   typedef struct packed {
      logic [31:0] addr;
      logic [16:0] len;
   } tfr_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [63:0] init_addr = '0;
   logic [63:0] addr_reg;
   logic [1:0]  err_state;
   logic        dma_int, adma_err, tfr_cmpl;
   logic        ack_int = 1'b0, ack_err = 1'b0, ack_tc = 1'b0;

   int unsigned vec_cnt = 0;
   int unsigned miscompares = 0;

   logic [63:0] fetch_q[$];
   tfr_t        tfr_q[$];
   logic [63:0] mem[logic [63:0]];
   bit          ack_en = 1'b1;
   int          mover_mode = 0;   // 0 done, 1 error, 2 never respond
   bit          ack_with_done = 1'b0;

   adma2_sequencer_if dif ();

   adma2_sequencer dut (
      .clk                          (clk),
      .reset_n                      (reset_n),
      .start                        (start),
      .abort                        (abort),
      .Initial_ADMA_System_Address  (init_addr),
      .dma_if                       (dif),
      .ADMA_System_Address_Register (addr_reg),
      .ADMA_Error_State             (err_state),
      .DMA_Interrupt                (dma_int),
      .ADMA_Error                   (adma_err),
      .Transfer_complete            (tfr_cmpl),
      .ack_DMA_Interrupt            (ack_int),
      .ack_ADMA_Error               (ack_err),
      .ack_Transfer_complete        (ack_tc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic kick(input logic [63:0] a);
      init_addr = a;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic ack_all();
      ack_int = 1'b1;
      ack_err = 1'b1;
      ack_tc  = 1'b1;
      @(negedge clk);
      ack_int = 1'b0;
      ack_err = 1'b0;
      ack_tc  = 1'b0;
   endtask

   task automatic chk_flags(input string tag, input logic i, input logic e, input logic t);
      chk({tag, "_int"}, 64'(dma_int), 64'(i));
      chk({tag, "_err"}, 64'(adma_err), 64'(e));
      chk({tag, "_tc"}, 64'(tfr_cmpl), 64'(t));
   endtask

   // Descriptor memory: one-cycle ack at the negedge after a request appears.
   initial begin
      dif.desc_ack  = 1'b0;
      dif.desc_data = '0;
      forever begin
         @(negedge clk);
         if (dif.desc_ack) begin
            dif.desc_ack = 1'b0;
         end else if (dif.desc_req && ack_en) begin
            dif.desc_ack  = 1'b1;
            dif.desc_data = mem.exists(dif.desc_addr) ? mem[dif.desc_addr] : 64'd0;
         end
      end
   end

   // Data mover: answers two cycles after tfr_start with a one-cycle done or error.
   initial begin
      dif.tfr_done  = 1'b0;
      dif.tfr_error = 1'b0;
      forever begin
         @(negedge clk);
         if (dif.tfr_start && mover_mode != 2) begin
            repeat (2) @(negedge clk);
            if (mover_mode == 1) dif.tfr_error = 1'b1;
            else dif.tfr_done = 1'b1;
            if (ack_with_done) ack_tc = 1'b1;
            @(negedge clk);
            dif.tfr_done  = 1'b0;
            dif.tfr_error = 1'b0;
            if (ack_with_done) ack_tc = 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard on each new fetch request and each tfr_start.
   initial begin
      logic        prev_req;
      logic [63:0] exp_a;
      tfr_t        exp_t;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (dif.desc_req && !prev_req) begin
            if (fetch_q.size() == 0) chk("fetch_unexpected", dif.desc_addr, 64'hdead);
            else begin
               exp_a = fetch_q.pop_front();
               chk("fetch_addr", dif.desc_addr, exp_a);
            end
         end
         prev_req = dif.desc_req;
         if (dif.tfr_start) begin
            if (tfr_q.size() == 0) chk("tfr_unexpected", 64'(dif.tfr_addr), 64'hdead);
            else begin
               exp_t = tfr_q.pop_front();
               chk("tfr_addr", 64'(dif.tfr_addr), 64'(exp_t.addr));
               chk("tfr_len", 64'(dif.tfr_len), 64'(exp_t.len));
            end
         end
      end
   end

   initial begin
      bit seen;
      repeat (2) @(negedge clk);
      chk("rst_desc_req", 64'(dif.desc_req), 64'd0);
      chk("rst_desc_addr", dif.desc_addr, 64'd0);
      chk("rst_tfr_start", 64'(dif.tfr_start), 64'd0);
      chk("rst_tfr_len", 64'(dif.tfr_len), 64'd0);
      chk("rst_addr_reg", addr_reg, 64'd0);
      chk("rst_err_state", 64'(err_state), 64'd0);
      chk_flags("rst", 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single transfer descriptor with int and end.
      mem[64'h10] = 64'h0000_1000_0200_0027;
      fetch_q.push_back(64'h10);
      tfr_q.push_back('{addr: 32'h1000, len: 17'd512});
      kick(64'h10);
      repeat (30) @(negedge clk);
      chk_flags("t1", 1'b1, 1'b0, 1'b1);
      chk("t1_addr_reg", addr_reg, 64'h18);
      ack_all();
      chk_flags("t1_ack", 1'b0, 1'b0, 1'b0);

      // nop -> link -> tran+end chain.
      mem[64'h10]  = 64'h0000_0000_0000_0001;
      mem[64'h18]  = 64'h0000_0100_0000_0031;
      mem[64'h100] = 64'h0000_2000_0040_0023;
      fetch_q.push_back(64'h10);
      fetch_q.push_back(64'h18);
      fetch_q.push_back(64'h100);
      tfr_q.push_back('{addr: 32'h2000, len: 17'd64});
      kick(64'h10);
      repeat (40) @(negedge clk);
      chk_flags("t2", 1'b0, 1'b0, 1'b1);
      chk("t2_addr_reg", addr_reg, 64'h108);
      ack_all();

      // Invalid descriptor.
      mem[64'h40] = 64'h0000_7000_0010_0026;
      fetch_q.push_back(64'h40);
      kick(64'h40);
      repeat (20) @(negedge clk);
      chk_flags("t3", 1'b0, 1'b1, 1'b0);
      chk("t3_err_state", 64'(err_state), 64'h1);
      ack_err = 1'b1;
      @(negedge clk);
      ack_err = 1'b0;
      chk("t3_err_acked", 64'(adma_err), 64'd0);

      // Length 0 means 65536 bytes.
      mem[64'h80] = 64'h0000_3000_0000_0023;
      fetch_q.push_back(64'h80);
      tfr_q.push_back('{addr: 32'h3000, len: 17'h1_0000});
      kick(64'h80);
      repeat (30) @(negedge clk);
      chk_flags("t4a", 1'b0, 1'b0, 1'b1);
      ack_all();

      // Data-mover error beats completion flags.
      mem[64'h90] = 64'h0000_4000_0010_0027;
      fetch_q.push_back(64'h90);
      tfr_q.push_back('{addr: 32'h4000, len: 17'd16});
      mover_mode = 1;
      kick(64'h90);
      repeat (30) @(negedge clk);
      chk_flags("t4b", 1'b0, 1'b1, 1'b0);
      chk("t4b_err_state", 64'(err_state), 64'h3);
      ack_all();

      // Abort during the transfer, then rerun from the initial address.
      mem[64'hA0] = 64'h0000_5000_0008_0027;
      fetch_q.push_back(64'hA0);
      tfr_q.push_back('{addr: 32'h5000, len: 17'd8});
      mover_mode = 2;
      kick(64'hA0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (dif.tfr_start) seen = 1'b1;
      end
      chk("t5_tfr_seen", 64'(seen), 64'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t5_abort_req", 64'(dif.desc_req), 64'd0);
      chk("t5_abort_len", 64'(dif.tfr_len), 64'd0);
      repeat (10) @(negedge clk);
      chk_flags("t5_abort", 1'b0, 1'b0, 1'b0);
      mover_mode = 0;
      fetch_q.push_back(64'hA0);
      tfr_q.push_back('{addr: 32'h5000, len: 17'd8});
      kick(64'hA0);
      repeat (30) @(negedge clk);
      chk_flags("t5_rerun", 1'b1, 1'b0, 1'b1);
      chk("t5_addr_reg", addr_reg, 64'hA8);
      ack_all();

      // Completion and host ack in the same cycle: the flag stays set.
      mem[64'hC0] = 64'h0000_6000_0004_0023;
      fetch_q.push_back(64'hC0);
      tfr_q.push_back('{addr: 32'h6000, len: 17'd4});
      ack_with_done = 1'b1;
      kick(64'hC0);
      repeat (30) @(negedge clk);
      ack_with_done = 1'b0;
      chk("t6_set_wins", 64'(tfr_cmpl), 64'd1);
      ack_all();

      // Withheld descriptor ack.
      ack_en = 1'b0;
      fetch_q.push_back(64'hD0);
      kick(64'hD0);
      repeat (1000) @(negedge clk);
      chk("t6_wait_req", 64'(dif.desc_req), 64'd1);
      chk("t6_wait_err", 64'(adma_err), 64'd0);
      repeat (40) @(negedge clk);
`ifdef ADMA_FETCH_TIMEOUT_EN
      chk("t6_to_err", 64'(adma_err), 64'd1);
      chk("t6_to_state", 64'(err_state), 64'h1);
      chk("t6_to_req", 64'(dif.desc_req), 64'd0);
`else
      chk("t6_still_req", 64'(dif.desc_req), 64'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t6_abort_req", 64'(dif.desc_req), 64'd0);
`endif
      ack_all();
      ack_en = 1'b1;

      repeat (5) @(negedge clk);
      chk("fetch_q_drained", 64'(fetch_q.size()), 64'd0);
      chk("tfr_q_drained", 64'(tfr_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

endmodule
